// File: rtl/router_pkt_source_if.sv
// Byte-stream bundle between the packet source and its user/router.
// The master modport is the source side; slave is whoever drives it.
interface router_pkt_source_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       start;
  logic [1:0] dest_addr;
  logic       inject_err;
  logic       busy;
  logic [7:0] dout;
  logic       pkt_valid;
  logic       tx_active;
  logic       done;
  logic [5:0] buf_count;
  logic       buf_full;
  logic       ovf;
  logic       cfg_err;

  modport master (
    input  wr_en, wr_data, start, dest_addr, inject_err, busy,
    output dout, pkt_valid, tx_active, done, buf_count, buf_full, ovf, cfg_err
  );

  modport slave (
    output wr_en, wr_data, start, dest_addr, inject_err, busy,
    input  dout, pkt_valid, tx_active, done, buf_count, buf_full, ovf, cfg_err
  );
endinterface

// File: rtl/router_pkt_source.sv
// Router packet source: buffers payload bytes, then emits header, payload and
// parity byte under the router's busy back-pressure.
module router_pkt_source #(
  parameter int         MAX_LEN  = 63,
  parameter logic [1:0] BAD_ADDR = 2'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  router_pkt_source_if.master  bus
);

  typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, PARITY, DONE} state_t;

  localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

  state_t     state_reg;
  logic [7:0] mem [MAX_LEN];
  logic [5:0] count_reg;
  logic [5:0] rd_idx_reg;
  logic [7:0] par_reg;
  logic [7:0] dout_reg;
  logic       inj_reg;
  logic       pkt_valid_reg;
  logic       tx_active_reg;
  logic       done_reg;
  logic       full_reg;
  logic       ovf_reg;
  logic       cfg_err_reg;

  logic       start_ok;
  logic       wr_ok;
  logic [5:0] rd_next;
  logic [5:0] rd_addr;
  logic [7:0] rd_byte;
  logic [7:0] header;

  assign header   = {count_reg, bus.dest_addr};
  assign start_ok = bus.start && (count_reg != 6'd0) && (bus.dest_addr != BAD_ADDR);
  // A start in the same cycle always wins over a write, accepted or not.
  assign wr_ok    = (state_reg == IDLE) && bus.wr_en && !bus.start && !full_reg;
  assign rd_next  = rd_idx_reg + 6'd1;
  assign rd_addr  = (state_reg == PAYLOAD) ? rd_next : 6'd0;
  assign rd_byte  = mem[rd_addr];

  // Buffer storage carries no reset; contents are only meaningful below count_reg.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[count_reg] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      count_reg     <= 6'd0;
      rd_idx_reg    <= 6'd0;
      par_reg       <= 8'd0;
      dout_reg      <= 8'd0;
      inj_reg       <= 1'b0;
      pkt_valid_reg <= 1'b0;
      tx_active_reg <= 1'b0;
      done_reg      <= 1'b0;
      full_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg    <= 1'b0;
          cfg_err_reg <= 1'b0;
          if (bus.start) begin
            if (start_ok) begin
              state_reg     <= HEADER;
              dout_reg      <= header;
              pkt_valid_reg <= 1'b1;
              tx_active_reg <= 1'b1;
              par_reg       <= par_reg ^ header;
              inj_reg       <= bus.inject_err;
              ovf_reg       <= 1'b0;
              rd_idx_reg    <= 6'd0;
            end else begin
              cfg_err_reg <= 1'b1;
            end
          end else if (bus.wr_en) begin
            if (!full_reg) begin
              count_reg <= count_reg + 6'd1;
              full_reg  <= (count_reg + 6'd1) == MAX_CNT;
              par_reg   <= par_reg ^ bus.wr_data;
            end else begin
              ovf_reg <= 1'b1;
            end
          end
        end

        HEADER: begin
          if (!bus.busy) begin
            state_reg  <= PAYLOAD;
            dout_reg   <= rd_byte;
            rd_idx_reg <= 6'd0;
          end
        end

        PAYLOAD: begin
          if (!bus.busy) begin
            if (rd_idx_reg == count_reg - 6'd1) begin
              state_reg     <= PARITY;
              dout_reg      <= par_reg ^ {7'b0, inj_reg};
              pkt_valid_reg <= 1'b0;
            end else begin
              rd_idx_reg <= rd_next;
              dout_reg   <= rd_byte;
            end
          end
        end

        PARITY: begin
          if (!bus.busy) begin
            state_reg     <= DONE;
            done_reg      <= 1'b1;
            tx_active_reg <= 1'b0;
            dout_reg      <= 8'd0;
            count_reg     <= 6'd0;
            full_reg      <= 1'b0;
            par_reg       <= 8'd0;
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.dout      = dout_reg;
  assign bus.pkt_valid = pkt_valid_reg;
  assign bus.tx_active = tx_active_reg;
  assign bus.done      = done_reg;
  assign bus.buf_count = count_reg;
  assign bus.buf_full  = full_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_router_pkt_source.sv
// Directed bench for router_pkt_source: frame content, back-pressure,
// full buffer, rejects, parity corruption and mid-frame reset.
module tb_router_pkt_source;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  router_pkt_source_if bus();

  router_pkt_source #(.MAX_LEN(63), .BAD_ADDR(2'd3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] cap_d[$];
  logic       cap_v[$];
  logic       cap_done;
  logic       cap_timeout;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic send_start(input logic [1:0] a, input logic inj);
    bus.start      = 1'b1;
    bus.dest_addr  = a;
    bus.inject_err = inj;
    step();
    bus.start      = 1'b0;
    bus.inject_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  // Records dout/pkt_valid each cycle while tx_active; stalls stall_n edges on stall_byte.
  task automatic capture(input logic [7:0] stall_byte, input int stall_n);
    int n;
    n = stall_n;
    cap_d.delete();
    cap_v.delete();
    cap_timeout = 1'b1;
    cap_done    = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!bus.tx_active) begin
        cap_timeout = 1'b0;
        break;
      end
      cap_d.push_back(bus.dout);
      cap_v.push_back(bus.pkt_valid);
      if (n > 0 && bus.pkt_valid && bus.dout == stall_byte) begin
        bus.busy = 1'b1;
        n--;
      end else begin
        bus.busy = 1'b0;
      end
      step();
    end
    bus.busy = 1'b0;
    cap_done = bus.done;
    $display("frame captured: %0d cycles, done=%0b", cap_d.size(), cap_done);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if ({bus.dout, bus.pkt_valid, bus.tx_active, bus.done, bus.buf_count,
         bus.buf_full, bus.ovf, bus.cfg_err} !== 20'd0) begin
      errors++;
      $display("FAIL reset_state: dout=%h pv=%b tx=%b done=%b cnt=%0d full=%b ovf=%b cfg=%b, all zero required",
               bus.dout, bus.pkt_valid, bus.tx_active, bus.done, bus.buf_count,
               bus.buf_full, bus.ovf, bus.cfg_err);
    end
    rst = 1'b1;
    $display("reset applied");
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    logic       exp_v [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    checks++;
    if (bus.buf_count !== 6'd3) begin
      errors++;
      $display("FAIL basic_count: got %0d expected 3", bus.buf_count);
    end
    send_start(2'd1, 1'b0);
    capture(8'h00, 0);
    checks++;
    if (cap_timeout || cap_d.size() != 5) begin
      errors++;
      $display("FAIL basic_len: got %0d (timeout=%b) expected 5", cap_d.size(), cap_timeout);
    end
    for (int i = 0; i < 5 && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_v[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL basic_byte%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_v[i], exp_d[i], exp_v[i]);
      end
    end
    checks++;
    if (cap_done !== 1'b1 || bus.buf_count !== 6'd0) begin
      errors++;
      $display("FAIL basic_done: done=%b cnt=%0d expected done=1 cnt=0", cap_done, bus.buf_count);
    end
    step();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b expected 0", bus.done);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [8] = '{8'h0D, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h0D};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    send_start(2'd1, 1'b0);
    capture(8'h22, 3);
    checks++;
    if (cap_timeout || cap_d.size() != 8) begin
      errors++;
      $display("FAIL bp_len: got %0d (timeout=%b) expected 8", cap_d.size(), cap_timeout);
    end
    for (int i = 0; i < 8 && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_v[i] !== (i != 7)) begin
        errors++;
        $display("FAIL bp_byte%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_v[i], exp_d[i], i != 7);
      end
    end
    step();
  endtask

  task automatic test_inject();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    send_start(2'd1, 1'b1);
    capture(8'h00, 0);
    checks++;
    if (cap_d.size() != 5 || cap_d[4] !== 8'h0C || cap_v[4] !== 1'b0) begin
      errors++;
      $display("FAIL inject_parity: len=%0d last=%h expected len 5 last 0c",
               cap_d.size(), cap_d.size() > 0 ? cap_d[cap_d.size()-1] : 8'hxx);
    end
    step();
  endtask

  task automatic test_full();
    logic [7:0] par;
    for (int i = 0; i < 64; i++) write_byte(8'(i + 1));
    checks++;
    if (bus.buf_count !== 6'd63 || bus.buf_full !== 1'b1 || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL full_flags: cnt=%0d full=%b ovf=%b expected 63/1/1", bus.buf_count, bus.buf_full, bus.ovf);
    end
    send_start(2'd2, 1'b0);
    checks++;
    if (bus.dout !== 8'hFE || bus.pkt_valid !== 1'b1 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_header: dout=%h pv=%b ovf=%b expected fe/1/0", bus.dout, bus.pkt_valid, bus.ovf);
    end
    capture(8'h00, 0);
    checks++;
    if (cap_timeout || cap_d.size() != 65) begin
      errors++;
      $display("FAIL full_len: got %0d (timeout=%b) expected 65", cap_d.size(), cap_timeout);
    end
    par = 8'hFE;
    for (int k = 1; k <= 63 && k < cap_d.size(); k++) begin
      par ^= 8'(k);
      checks++;
      if (cap_d[k] !== 8'(k) || cap_v[k] !== 1'b1) begin
        errors++;
        $display("FAIL full_byte%0d: got %h/%b expected %h/1", k, cap_d[k], cap_v[k], 8'(k));
      end
    end
    checks++;
    if (cap_d.size() != 65 || cap_d[64] !== par || cap_v[64] !== 1'b0 || bus.buf_full !== 1'b0) begin
      errors++;
      $display("FAIL full_parity: got %h expected %h, full=%b",
               cap_d.size() == 65 ? cap_d[64] : 8'hxx, par, bus.buf_full);
    end
    step();
  endtask

  task automatic test_rejects();
    send_start(2'd0, 1'b0);
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.pkt_valid !== 1'b0 || bus.tx_active !== 1'b0) begin
      errors++;
      $display("FAIL reject_empty: cfg=%b pv=%b tx=%b expected 1/0/0", bus.cfg_err, bus.pkt_valid, bus.tx_active);
    end
    step();
    checks++;
    if (bus.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reject_pulse: cfg=%b expected 0", bus.cfg_err);
    end
    write_byte(8'h5A);
    write_byte(8'hC3);
    send_start(2'd3, 1'b0);
    checks++;
    if (bus.cfg_err !== 1'b1 || bus.buf_count !== 6'd2 || bus.pkt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reject_addr: cfg=%b cnt=%0d pv=%b expected 1/2/0", bus.cfg_err, bus.buf_count, bus.pkt_valid);
    end
    step();
    checks++;
    if (bus.tx_active !== 1'b0 || bus.buf_count !== 6'd2) begin
      errors++;
      $display("FAIL reject_idle: tx=%b cnt=%0d expected 0/2", bus.tx_active, bus.buf_count);
    end
    apply_reset();
    $display("rejects done");
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp_d [3] = '{8'h04, 8'hA5, 8'hA1};
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    send_start(2'd1, 1'b0);
    step();
    step();
    checks++;
    if (bus.dout !== 8'h22 || bus.pkt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_byte1: dout=%h pv=%b expected 22/1", bus.dout, bus.pkt_valid);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (bus.pkt_valid !== 1'b0 || bus.dout !== 8'h00 || bus.buf_count !== 6'd0 || bus.tx_active !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: pv=%b dout=%h cnt=%0d tx=%b expected 0/00/0/0",
               bus.pkt_valid, bus.dout, bus.buf_count, bus.tx_active);
    end
    write_byte(8'hA5);
    send_start(2'd0, 1'b0);
    capture(8'h00, 0);
    checks++;
    if (cap_timeout || cap_d.size() != 3) begin
      errors++;
      $display("FAIL mid_len: got %0d (timeout=%b) expected 3", cap_d.size(), cap_timeout);
    end
    for (int i = 0; i < 3 && i < cap_d.size(); i++) begin
      checks++;
      if (cap_d[i] !== exp_d[i] || cap_v[i] !== (i != 2)) begin
        errors++;
        $display("FAIL mid_byte%0d: got %h/%b expected %h/%b", i, cap_d[i], cap_v[i], exp_d[i], i != 2);
      end
    end
    step();
  endtask

  initial begin
    rst            = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_data    = 8'h00;
    bus.start      = 1'b0;
    bus.dest_addr  = 2'd0;
    bus.inject_err = 1'b0;
    bus.busy       = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_inject();
    test_full();
    test_rejects();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_pkt_source.md
Name: router_pkt_source

Overview:
- Packet transmitter for the router's input port; it is the source side of the header/payload/parity protocol the router receive path checks.
- Payload bytes are buffered locally first. On start, the block emits one frame: header (length, address), payload, then a parity byte.
- Honours the router's busy back-pressure.
- Used as the traffic source in router bring-up and as the upstream master in the top-level test harness.

Parameters:
- MAX_LEN, 63: payload buffer depth. Fixed by the 6-bit length field; must be 1..63.
- BAD_ADDR, 3: destination address treated as invalid; start with it is rejected.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- wr_en  in  1  write one payload byte into the buffer
- wr_data  in  8  payload byte
- start  in  1  begin transmitting the buffered packet
- dest_addr  in  2  destination port, sampled on accepted start
- inject_err  in  1  sampled on accepted start; corrupts the parity byte
- busy  in  1  router back-pressure; the byte on dout is consumed only at an edge with busy=0
- dout  out  8  packet byte to the router
- pkt_valid  out  1  high during header and payload, low during the parity byte
- tx_active  out  1  high from HEADER through PARITY
- done  out  1  one-cycle pulse after the parity byte is consumed
- buf_count  out  6  bytes currently buffered
- buf_full  out  1  buf_count == MAX_LEN
- ovf  out  1  sticky; a write was attempted while full. Cleared by reset or an accepted start.
- cfg_err  out  1  one-cycle pulse; start rejected because buf_count==0 or dest_addr==BAD_ADDR

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE; dout=0, pkt_valid=0, tx_active=0, done=0, cfg_err=0, ovf=0, buf_count=0.
  - Running parity=0. Buffer contents are don't-care.
  - Reset mid-packet abandons the frame; no parity byte is sent.
- All outputs are registered.
- States: IDLE, HEADER, PAYLOAD, PARITY, DONE.
- IDLE, writes:
  - wr_en with !buf_full stores the byte at index buf_count, increments buf_count, and XORs the byte into the running parity.
  - wr_en while full leaves contents unchanged and sets ovf.
  - wr_en outside IDLE is ignored; ovf is not set.
- IDLE, start:
  - start with buf_count>0 and dest_addr!=BAD_ADDR is accepted. Next cycle: state=HEADER, dout={buf_count,dest_addr}, pkt_valid=1, tx_active=1.
  - On acceptance: running parity ^= header; inject_err is latched; ovf is cleared; the read index is set to 0.
  - Start otherwise is rejected: cfg_err pulses next cycle, state stays IDLE, buffer is untouched.
  - start and wr_en in the same cycle: start has priority and the write is dropped.
- HEADER:
  - At an edge with busy=0, go to PAYLOAD with dout=buffer[0].
  - While busy=1, dout and pkt_valid hold.
- PAYLOAD:
  - Each edge with busy=0 advances the read index; busy=1 holds the byte.
  - When the last byte (index buf_count-1) is consumed, go to PARITY with dout=parity ^ {7'b0,inject_latched} and pkt_valid=0.
- PARITY:
  - At an edge with busy=0, go to DONE: done=1, tx_active=0, dout=0.
  - buf_count and running parity are cleared.
- DONE: one cycle, then IDLE. Start in DONE is ignored.
- Latency and throughput:
  - Start-to-first-header is 1 cycle.
  - With busy=0 throughout, a frame is N+2 consecutive cycles (header, N payload bytes, parity), then the done cycle.
  - Minimum start-to-start spacing is N+4 cycles, not counting reload writes.
- busy asserted in DONE or IDLE has no effect.
- Header field: bits[7:2]=length (1..63), bits[1:0]=address. Parity is the XOR of the header and all payload bytes.

Test Plan:
- Basic frame: write 0x11,0x22,0x33; start dest_addr=1, busy=0 → dout sequence 0x0D,0x11,0x22,0x33 with pkt_valid=1, then 0x0D with pkt_valid=0; done pulses; buf_count=0 after.
- Back-pressure: same frame, busy=1 for 3 cycles while dout=0x22 → dout holds 0x22 for 4 cycles; rest of sequence and parity unchanged; total frame length 8 cycles.
- Full buffer: 64 writes → buf_count=63, buf_full=1, ovf=1; start dest_addr=2 → header 0xFE, 63 payload bytes; ovf clears on start.
- Rejects: start with buf_count=0 → cfg_err pulse, no pkt_valid. Start with 2 bytes and dest_addr=3 → cfg_err pulse, buf_count stays 2.
- Error injection: basic frame with inject_err=1 at start → parity byte 0x0C.
- Reset mid-frame: rst=0 during PAYLOAD byte 1 → next cycle pkt_valid=0, dout=0, buf_count=0, state IDLE; a new 1-byte frame 0xA5 to addr 0 gives header 0x04, parity 0xA1.
